// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor. Operands are latched on start,
// then one bit per clock goes through a single full-adder cell, LSB first.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_part;
    logic             r_c;
    logic [CW-1:0]    r_cnt;

    logic             w_s;
    logic             w_cout;
    logic             w_last;
    logic             w_load;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_part_next;

    always_comb begin
        w_s         = r_opa[0] ^ r_opb[0] ^ r_c;
        w_cout      = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_c) | (r_opb[0] & r_c);
        w_last      = (r_cnt == CW'(WIDTH - 1));
        w_load      = start && (r_state != S_SHIFT);
        // Sum bit enters at the MSB; slicing the extended vector keeps WIDTH=1 legal.
        w_ext       = {w_s, r_part};
        w_part_next = w_ext[WIDTH:1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = start ? S_SHIFT : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa  <= '0;
            r_opb  <= '0;
            r_part <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            result <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
        end else if (w_load) begin
            r_opa <= a;
            r_opb <= sub ? ~b : b;
            r_c   <= sub;
            r_cnt <= '0;
        end else if (r_state == S_SHIFT) begin
            r_opa  <= r_opa >> 1;
            r_opb  <= r_opb >> 1;
            r_c    <= w_cout;
            r_part <= w_part_next;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
                result <= w_part_next;
                carry  <= w_cout;
                ovf    <= r_c ^ w_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed vector table, randomized
// operations against an arithmetic model, WIDTH=1 exhaustive, handshake and reset cases.
module tb_serial_add_sub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, carry, ovf;
    logic [7:0] result;

    logic       s1_start = 1'b0;
    logic       s1_sub = 1'b0;
    logic [0:0] s1_a = '0;
    logic [0:0] s1_b = '0;
    logic       s1_busy, s1_done, s1_carry, s1_ovf;
    logic [0:0] s1_result;

    int errors = 0;
    int checks = 0;
    int last_res = 0;

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry(carry), .ovf(ovf)
    );

    serial_add_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .sub(s1_sub), .a(s1_a), .b(s1_b),
        .busy(s1_busy), .done(s1_done), .result(s1_result), .carry(s1_carry), .ovf(s1_ovf)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] r;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: integer sum/difference and signed range test.
    function automatic void model(input int w, input int ua, input int ub, input bit s,
                                  output int r, output bit c, output bit v);
        int m;
        int sa;
        int sb;
        int full;
        int sr;
        m    = 1 << w;
        sa   = (ua >= m / 2) ? ua - m : ua;
        sb   = (ub >= m / 2) ? ub - m : ub;
        full = s ? (ua - ub + m) : (ua + ub);
        r    = full % m;
        c    = (full >= m);
        sr   = s ? (sa - sb) : (sa + sb);
        v    = (sr < -(m / 2)) || (sr > (m / 2 - 1));
    endfunction

    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                         input int er, input bit ec, input bit ev, input string tag);
        int lat;
        lat = -1;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; sub = ts;
        @(posedge clk); #1;
        chk({tag, " busy@E0"}, busy, 1);
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
            if (result != 8'(last_res)) chk({tag, " hold"}, result, last_res);
        end
        chk({tag, " latency"}, lat, 8);
        chk({tag, " result"}, result, er);
        chk({tag, " carry"}, carry, ec);
        chk({tag, " ovf"}, ovf, ev);
        last_res = er;
        @(posedge clk); #1;
        chk({tag, " done pulse"}, done, 0);
    endtask

    task automatic do_op1(input int ta, input int tb_v, input bit ts);
        int  er;
        bit  ec;
        bit  ev;
        string tag;
        model(1, ta, tb_v, ts, er, ec, ev);
        tag = $sformatf("w1 a=%0d b=%0d s=%0d", ta, tb_v, ts);
        @(negedge clk);
        s1_start = 1'b1; s1_a = 1'(ta); s1_b = 1'(tb_v); s1_sub = ts;
        @(posedge clk); #1;
        chk({tag, " busy"}, s1_busy, 1);
        @(negedge clk);
        s1_start = 1'b0; s1_a = ~s1_a; s1_b = ~s1_b;
        @(posedge clk); #1;
        chk({tag, " done"}, s1_done, 1);
        chk({tag, " result"}, s1_result, er);
        chk({tag, " carry"}, s1_carry, ec);
        chk({tag, " ovf"}, s1_ovf, ev);
    endtask

    initial begin
        int  first;
        int  ndone;
        int  second;
        int  er;
        bit  ec;
        bit  ev;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[9] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset carry", carry, 0);
        chk("reset ovf", ovf, 0);
        chk("reset w1 busy", s1_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].r, vecs[i].c, vecs[i].v,
                  $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            model(8, ra, rb, rs, er, ec, ev);
            do_op(ra, rb, rs, er, ec, ev, $sformatf("rnd%0d", i));
        end

        for (int i = 0; i < 8; i++)
            do_op1(i & 1, (i >> 1) & 1, bit'((i >> 2) & 1));

        // Start ignored while busy, then back-to-back start in the done cycle.
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        first = -1;
        ndone = 0;
        for (int k = 4; k <= 8; k++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                first = k;
            end
        end
        chk("b2b done count", ndone, 1);
        chk("b2b done edge", first, 8);
        chk("b2b result", result, 8'h02);
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0;
        @(posedge clk); #1;
        chk("b2b restart busy", busy, 1);
        chk("b2b restart done", done, 0);
        @(negedge clk);
        start = 1'b0;
        second = -1;
        for (int k = 10; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done) begin
                second = k;
                break;
            end
        end
        chk("b2b second done edge", second, 17);
        chk("b2b second result", result, 8'h46);
        last_res = 8'h46;

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; a = 8'h55; b = 8'h22; sub = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst busy", busy, 0);
        chk("async rst done", done, 0);
        chk("async rst result", result, 0);
        chk("async rst carry", carry, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("no done after abort", ndone, 0);
        last_res = 0;
        do_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, "post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
